round_history_recorder: RTL and testbench

- Sits directly downstream of the guess-grading stage in the Lab5 game datapath.
- On every graded round, captures the graded guess and its Znarly/Zood counts into an 8-entry history buffer.
- Tracks the best round and whether the game has closed.
- Gives the display/debug logic random-access, registered readback of any past round.

---
 rtl/round_history_recorder_if.sv | 43 ++++
 rtl/round_history_recorder.sv | 110 +++++++++++
 tb/tb_round_history_recorder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/round_history_recorder_if.sv
`default_nettype none
// ============================================================================
// Module      : round_history_recorder_if
// Description : Grade-capture and history-readback bundle for the round
//               history recorder.
// Revision    : 1.0 - initial release
// ============================================================================
interface round_history_recorder_if #(
    parameter int IDX_W = 3,
    parameter int PAT_W = 12
);
    logic             StartGame;
    logic             GradeDone;
    logic [PAT_W-1:0] Guess;
    logic [3:0]       Znarly;
    logic [3:0]       Zood;
    logic             GameWon;
    logic             ReadEn;
    logic [IDX_W-1:0] ReadIndex;
    logic [PAT_W-1:0] ReadGuess;
    logic [3:0]       ReadZnarly;
    logic [3:0]       ReadZood;
    logic             ReadValid;
    logic [3:0]       NumRecorded;
    logic [3:0]       BestZnarly;
    logic [3:0]       BestRound;
    logic             Recording;
    logic             Closed;
    logic             Overflow;

    modport master (
        output StartGame, GradeDone, Guess, Znarly, Zood, GameWon, ReadEn, ReadIndex,
        input  ReadGuess, ReadZnarly, ReadZood, ReadValid, NumRecorded,
               BestZnarly, BestRound, Recording, Closed, Overflow
    );

    modport slave (
        input  StartGame, GradeDone, Guess, Znarly, Zood, GameWon, ReadEn, ReadIndex,
        output ReadGuess, ReadZnarly, ReadZood, ReadValid, NumRecorded,
               BestZnarly, BestRound, Recording, Closed, Overflow
    );
endinterface
`default_nettype wire

// File: rtl/round_history_recorder.sv
`default_nettype none
// ============================================================================
// Module      : round_history_recorder
// Description : Records each graded round into a DEPTH-entry history, tracks
//               the best round and game closure, and offers registered readback.
// Revision    : 1.0 - initial release
// ============================================================================
module round_history_recorder #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3,
    parameter int PAT_W = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    round_history_recorder_if.slave bus
);
    localparam int ENT_W = PAT_W + 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [ENT_W-1:0] entries [DEPTH];
    logic [3:0]       num_rec;
    logic [3:0]       best_zn;
    logic [3:0]       best_round;
    logic             recording;
    logic             closed;
    logic             overflow;
    logic [PAT_W-1:0] rd_guess;
    logic [3:0]       rd_zn;
    logic [3:0]       rd_zd;
    logic             rd_valid;

    logic [3:0]       num_next;
    logic             read_hit;

    assign num_next = num_rec + 4'd1;
    // Compared against the pre-write count, so a same-cycle write is not yet visible.
    assign read_hit = 4'(bus.ReadIndex) < num_rec;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            recording  <= 1'b0;
            closed     <= 1'b0;
            overflow   <= 1'b0;
            num_rec    <= 4'd0;
            best_zn    <= 4'd0;
            best_round <= 4'd0;
            rd_guess   <= '0;
            rd_zn      <= 4'd0;
            rd_zd      <= 4'd0;
            rd_valid   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (bus.ReadEn) begin
                rd_valid                  <= read_hit;
                {rd_guess, rd_zn, rd_zd}  <= read_hit ? entries[bus.ReadIndex] : '0;
            end

            if (bus.StartGame) begin
                state      <= REC;
                recording  <= 1'b1;
                closed     <= 1'b0;
                overflow   <= 1'b0;
                num_rec    <= 4'd0;
                best_zn    <= 4'd0;
                best_round <= 4'd0;
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i] <= '0;
                end
            end else if (bus.GradeDone) begin
                if (state == REC) begin
                    entries[num_rec[IDX_W-1:0]] <= {bus.Guess, bus.Znarly, bus.Zood};
                    num_rec <= num_next;
                    // Strict compare: a tie keeps the earlier round.
                    if (bus.Znarly > best_zn) begin
                        best_zn    <= bus.Znarly;
                        best_round <= num_next;
                    end
                    if (bus.GameWon || (num_next == 4'(DEPTH))) begin
                        state     <= DONE;
                        recording <= 1'b0;
                        closed    <= 1'b1;
                    end
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    assign bus.ReadGuess   = rd_guess;
    assign bus.ReadZnarly  = rd_zn;
    assign bus.ReadZood    = rd_zd;
    assign bus.ReadValid   = rd_valid;
    assign bus.NumRecorded = num_rec;
    assign bus.BestZnarly  = best_zn;
    assign bus.BestRound   = best_round;
    assign bus.Recording   = recording;
    assign bus.Closed      = closed;
    assign bus.Overflow    = overflow;
endmodule
`default_nettype wire

// File: tb/tb_round_history_recorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_history_recorder
// Description : Directed scoreboard bench for round_history_recorder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_history_recorder;
    logic clock;
    logic reset;

    round_history_recorder_if #(.IDX_W(3), .PAT_W(12)) bus ();

    round_history_recorder #(.DEPTH(8), .IDX_W(3), .PAT_W(12)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string      name;
        logic [3:0] num;
        logic [3:0] best;
        logic [3:0] bround;
        logic       rec;
        logic       closed;
        logic       ovf;
        bit         chk_rd;
    } stat_t;

    typedef struct {
        string       name;
        logic        v;
        logic [11:0] g;
        logic [3:0]  zn;
        logic [3:0]  zd;
    } rd_t;

    stat_t stat_q[$];
    rd_t   read_q[$];
    int    checks    = 0;
    int    errors    = 0;
    int    rd_issued = 0;
    int    rd_done   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    always @(posedge clock) begin
        if (!reset && bus.ReadEn) rd_issued++;
    end

    // Monitor: compares queued expectations against outputs on the falling edge.
    always @(negedge clock) begin
        stat_t s;
        rd_t   r;
        while (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            checks++;
            if ({bus.NumRecorded, bus.BestZnarly, bus.BestRound, bus.Recording, bus.Closed, bus.Overflow}
                !== {s.num, s.best, s.bround, s.rec, s.closed, s.ovf}) begin
                errors++;
                $display("FAIL %s: got num=%0d best=%0d round=%0d rec=%0b closed=%0b ovf=%0b, required num=%0d best=%0d round=%0d rec=%0b closed=%0b ovf=%0b",
                         s.name, bus.NumRecorded, bus.BestZnarly, bus.BestRound, bus.Recording, bus.Closed, bus.Overflow,
                         s.num, s.best, s.bround, s.rec, s.closed, s.ovf);
            end
            if (s.chk_rd) begin
                checks++;
                if ({bus.ReadValid, bus.ReadGuess, bus.ReadZnarly, bus.ReadZood} !== 21'd0) begin
                    errors++;
                    $display("FAIL %s_read_regs: got v=%0b g=%h zn=%0d zd=%0d, required all 0",
                             s.name, bus.ReadValid, bus.ReadGuess, bus.ReadZnarly, bus.ReadZood);
                end
            end
        end
        while (rd_done < rd_issued) begin
            rd_done++;
            checks++;
            if (read_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: got a read response, required no pending read");
            end else begin
                r = read_q.pop_front();
                if ({bus.ReadValid, bus.ReadGuess, bus.ReadZnarly, bus.ReadZood} !== {r.v, r.g, r.zn, r.zd}) begin
                    errors++;
                    $display("FAIL %s: got v=%0b g=%h zn=%0d zd=%0d, required v=%0b g=%h zn=%0d zd=%0d",
                             r.name, bus.ReadValid, bus.ReadGuess, bus.ReadZnarly, bus.ReadZood,
                             r.v, r.g, r.zn, r.zd);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_status(input string name, input logic [3:0] num, input logic [3:0] best,
                                 input logic [3:0] bround, input logic rec, input logic closed,
                                 input logic ovf, input bit chk_rd = 1'b0);
        stat_t s;
        s.name = name; s.num = num; s.best = best; s.bround = bround;
        s.rec = rec; s.closed = closed; s.ovf = ovf; s.chk_rd = chk_rd;
        stat_q.push_back(s);
    endtask

    task automatic push_read(input string name, input logic v, input logic [11:0] g,
                             input logic [3:0] zn, input logic [3:0] zd);
        rd_t r;
        r.name = name; r.v = v; r.g = g; r.zn = zn; r.zd = zd;
        read_q.push_back(r);
    endtask

    task automatic start_game();
        bus.StartGame = 1'b1;
        cycle();
        bus.StartGame = 1'b0;
    endtask

    task automatic grade(input logic [11:0] g, input logic [3:0] zn, input logic [3:0] zd, input logic won);
        bus.GradeDone = 1'b1; bus.Guess = g; bus.Znarly = zn; bus.Zood = zd; bus.GameWon = won;
        cycle();
        bus.GradeDone = 1'b0; bus.GameWon = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [2:0] idx, input logic v,
                           input logic [11:0] g, input logic [3:0] zn, input logic [3:0] zd);
        bus.ReadEn = 1'b1; bus.ReadIndex = idx;
        push_read(name, v, g, zn, zd);
        cycle();
        bus.ReadEn = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.StartGame = 1'b0; bus.GradeDone = 1'b0; bus.Guess = '0; bus.Znarly = '0;
        bus.Zood = '0; bus.GameWon = 1'b0; bus.ReadEn = 1'b0; bus.ReadIndex = '0;
        cycle();
        expect_status("reset_state", 0, 0, 0, 0, 0, 0, 1'b1);
        cycle();
        reset = 1'b0;
        cycle();

        // Basic recording and best tracking
        start_game();
        expect_status("start_game", 0, 0, 0, 1, 0, 0);
        grade(12'h111, 1, 2, 0);
        grade(12'h249, 3, 0, 0);
        grade(12'h24A, 3, 1, 0);
        expect_status("three_rounds", 3, 3, 2, 1, 0, 0);
        do_read("read_idx1", 1, 1, 12'h249, 3, 0);
        do_read("read_unrecorded", 5, 0, 12'h000, 0, 0);
        grade(12'hABC, 9, 7, 0);
        expect_status("znarly_above4", 4, 9, 4, 1, 0, 0);
        do_read("read_idx3_raw", 3, 1, 12'hABC, 9, 7);

        // Win closes the game
        start_game();
        grade(12'h001, 1, 0, 0);
        grade(12'h002, 2, 0, 0);
        grade(12'h003, 4, 0, 1);
        expect_status("game_won", 3, 4, 3, 0, 1, 0);
        grade(12'h005, 0, 0, 0);
        expect_status("grade_after_done", 3, 4, 3, 0, 1, 1);

        // Depth limit
        start_game();
        expect_status("restart_clears_ovf", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            grade(12'h100 + 12'(i), (i == 5) ? 4'd2 : 4'd1, 0, 0);
        end
        expect_status("depth_reached", 8, 2, 6, 0, 1, 0);
        grade(12'h1FF, 4, 0, 0);
        expect_status("ninth_grade", 8, 2, 6, 0, 1, 1);
        do_read("read_idx7", 7, 1, 12'h107, 1, 0);

        // StartGame beats GradeDone; read in that cycle sees pre-clear data
        start_game();
        for (int i = 0; i < 4; i++) begin
            grade(12'h201 + 12'(i), 1, 0, 0);
        end
        expect_status("four_rounds", 4, 1, 1, 1, 0, 0);
        bus.StartGame = 1'b1; bus.GradeDone = 1'b1; bus.Guess = 12'hFFF; bus.Znarly = 4;
        bus.ReadEn = 1'b1; bus.ReadIndex = 0;
        push_read("read_during_start", 1, 12'h201, 1, 0);
        cycle();
        bus.StartGame = 1'b0; bus.GradeDone = 1'b0; bus.ReadEn = 1'b0;
        expect_status("start_priority", 0, 0, 0, 1, 0, 0);
        do_read("read_after_clear", 0, 0, 12'h000, 0, 0);

        // Read/write collision
        grade(12'h301, 1, 1, 0);
        grade(12'h302, 2, 0, 0);
        bus.GradeDone = 1'b1; bus.Guess = 12'h2AA; bus.Znarly = 2; bus.Zood = 2;
        bus.ReadEn = 1'b1; bus.ReadIndex = 2;
        push_read("read_collision", 0, 12'h000, 0, 0);
        cycle();
        bus.GradeDone = 1'b0; bus.ReadEn = 1'b0;
        expect_status("tie_keeps_earlier", 3, 2, 2, 1, 0, 0);
        do_read("reread_idx2", 2, 1, 12'h2AA, 2, 2);

        // Asynchronous reset mid-game
        grade(12'h303, 0, 0, 0);
        grade(12'h304, 0, 0, 0);
        expect_status("five_rounds", 5, 2, 2, 1, 0, 0);
        cycle();
        reset = 1'b1;
        #1;
        expect_status("async_reset", 0, 0, 0, 0, 0, 0, 1'b1);
        cycle();
        reset = 1'b0;
        grade(12'h777, 3, 0, 0);
        expect_status("grade_in_idle", 0, 0, 0, 0, 0, 1);

        cycle();
        cycle();
        checks++;
        if (read_q.size() != 0 || stat_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: got %0d reads and %0d status pending, required 0",
                     read_q.size(), stat_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
